// File: rtl/axil_mem_responder.sv
// axil_mem_responder: AXI-lite-style slave memory for the MEM stage.
// Word-organised array with byte-strobe writes, independent read and write
// channels (one outstanding transaction each), parameterised response latency.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   araddr/arvalid/arready      read address channel
//   rdata/rresp/rvalid/rready   read data channel (rresp 00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready      write address channel
//   wdata/wstrb/wvalid/wready   write data channel
//   bresp/bvalid/bready         write response channel
module axil_mem_responder #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned            RD_LATENCY  = 2,
  parameter int unsigned            WR_LATENCY  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned RC_W   = $clog2(RD_LATENCY + 1);
  localparam int unsigned WC_W   = $clog2(WR_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] SPAN_BYTES = ADDR_WIDTH'(DEPTH_WORDS * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  rd_state_t             r_rd_state;
  logic [RC_W-1:0]       r_rcnt;
  logic [ADDR_WIDTH-1:0] r_raddr;

  wr_state_t             r_wr_state;
  logic [WC_W-1:0]       r_wcnt;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;

  // Address decode for the latched read and write addresses
  logic [ADDR_WIDTH-1:0] w_roff, w_woff;
  logic                  w_rin, w_win;
  logic [IDX_W-1:0]      w_ridx, w_widx;
  assign w_roff = r_raddr - BASE_ADDR;
  assign w_woff = r_waddr - BASE_ADDR;
  assign w_rin  = (w_roff < SPAN_BYTES);
  assign w_win  = (w_woff < SPAN_BYTES);
  assign w_ridx = w_roff[IDX_W+1:2];
  assign w_widx = w_woff[IDX_W+1:2];

  // Commit fires on the last wait cycle; a reset in that cycle abandons it
  logic w_wcommit;
  assign w_wcommit = rst_n && (r_wr_state == W_WAIT) && (r_wcnt == '0) && w_win;

  // Read word with write-first bypass, merged per byte
  logic [DATA_WIDTH-1:0] w_rd_word;
  always_comb begin
    w_rd_word = r_mem[w_ridx];
    if (w_wcommit && (w_widx == w_ridx)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (r_wstrb[i]) w_rd_word[8*i +: 8] = r_wdata[8*i +: 8];
      end
    end
  end

  // Array storage, never reset
  always_ff @(posedge clk) begin
    if (w_wcommit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (r_wstrb[i]) r_mem[w_widx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  // Read channel FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_state <= R_IDLE;
      r_rcnt     <= '0;
      r_raddr    <= '0;
      arready    <= 1'b1;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rresp      <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (arvalid) begin
            r_raddr    <= araddr;
            r_rcnt     <= RC_W'(RD_LATENCY - 1);
            arready    <= 1'b0;
            r_rd_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_rcnt == '0) begin
            rdata      <= w_rin ? w_rd_word : '0;
            rresp      <= w_rin ? RESP_OKAY : RESP_SLVERR;
            rvalid     <= 1'b1;
            r_rd_state <= R_RESP;
          end else begin
            r_rcnt <= r_rcnt - RC_W'(1);
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid     <= 1'b0;
            arready    <= 1'b1;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Write channel FSM; AW and W are collected independently in W_IDLE
  logic w_aw_hs, w_w_hs;
  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_state <= W_IDLE;
      r_wcnt     <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      awready    <= 1'b1;
      wready     <= 1'b1;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_waddr <= awaddr;
            awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            wready  <= 1'b0;
          end
          // Both halves held once each has handshaken now or earlier
          if ((w_aw_hs || !awready) && (w_w_hs || !wready)) begin
            r_wcnt     <= WC_W'(WR_LATENCY - 1);
            r_wr_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (r_wcnt == '0) begin
            bvalid     <= 1'b1;
            bresp      <= w_win ? RESP_OKAY : RESP_SLVERR;
            r_wr_state <= W_RESP;
          end else begin
            r_wcnt <= r_wcnt - WC_W'(1);
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid     <= 1'b0;
            awready    <= 1'b1;
            wready     <= 1'b1;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_mem_responder.sv
// Self-checking bench for axil_mem_responder: directed cases plus a random
// read/write mix compared against a word/byte-mask memory model.
module tb_axil_mem_responder;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WR_LAT = 1;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] SPAN   = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int errors = 0;
  int checks = 0;

  axil_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference memory: word index -> contents
  logic [31:0] mdl [int unsigned];

  function automatic bit in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return off < SPAN;
  endfunction

  function automatic int unsigned widx(input logic [31:0] addr);
    return int'((addr - BASE) >> 2);
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] mask, old;
    if (!in_range(addr)) return 2'b10;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    old  = mdl.exists(widx(addr)) ? mdl[widx(addr)] : 32'h0;
    mdl[widx(addr)] = (old & ~mask) | (data & mask);
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (!in_range(addr)) return 32'h0;
    return mdl.exists(widx(addr)) ? mdl[widx(addr)] : 32'h0;
  endfunction

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    int cyc = 0;
    int lat;
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    logic [1:0] exp_resp;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      if (aw_done && !w_done) check({tag, "/awready_low"}, 32'(awready), 32'd0);
      if (w_done && !aw_done) check({tag, "/wready_low"}, 32'(wready), 32'd0);
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      hs_aw   = awvalid && awready;
      hs_w    = wvalid && wready;
      @(posedge clk);
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      cyc++;
    end
    check({tag, "/handshakes"}, 32'({aw_done, w_done}), 32'd3);
    exp_resp = model_write(addr, data, strb);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 0;
    while (bvalid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "/b_latency"}, 32'(lat), 32'(WR_LAT));
    check({tag, "/bresp"}, 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    check({tag, "/bvalid_clr"}, 32'(bvalid), 32'd0);
    check({tag, "/ready_back"}, 32'({awready, wready}), 32'd3);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr, input int rdly,
                          output logic [31:0] got);
    int lat;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = model_read(addr);
    exp_resp = in_range(addr) ? 2'b00 : 2'b10;
    @(negedge clk);
    check({tag, "/arready_idle"}, 32'(arready), 32'd1);
    arvalid = 1'b1;
    araddr  = addr;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check({tag, "/arready_busy"}, 32'(arready), 32'd0);
    lat = 0;
    while (rvalid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "/r_latency"}, 32'(lat), 32'(RD_LAT));
    check({tag, "/rdata"}, rdata, exp_data);
    check({tag, "/rresp"}, 32'(rresp), 32'(exp_resp));
    got = rdata;
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "/hold_rvalid"}, 32'(rvalid), 32'd1);
      check({tag, "/hold_rdata"}, rdata, exp_data);
      check({tag, "/hold_rresp"}, 32'(rresp), 32'(exp_resp));
      check({tag, "/hold_arready"}, 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    check({tag, "/rvalid_clr"}, 32'(rvalid), 32'd0);
    check({tag, "/arready_back"}, 32'(arready), 32'd1);
  endtask

  logic [31:0] got;
  logic [31:0] pool [8];
  logic [31:0] addr_r;
  logic [1:0]  dummy;

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/arready", 32'(arready), 32'd1);
    check("rst/awready", 32'(awready), 32'd1);
    check("rst/wready", 32'(wready), 32'd1);
    check("rst/rvalid", 32'(rvalid), 32'd0);
    check("rst/bvalid", 32'(bvalid), 32'd0);
    check("rst/rdata", rdata, 32'd0);
    check("rst/rresp", 32'(rresp), 32'd0);
    check("rst/bresp", 32'(bresp), 32'd0);
    rst_n = 1'b1;

    // Basic write then read
    axi_write("t1w", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
    axi_read("t1r", 32'h8000_0010, 0, got);
    check("t1/value", got, 32'hDEAD_BEEF);

    // Partial strobe merge
    axi_write("t2a", 32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0);
    axi_write("t2b", 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, 0);
    axi_read("t2r", 32'h8000_0020, 0, got);
    check("t2/value", got, 32'h11BB_33DD);

    // AW first, W three cycles later; W first variant; zero strobe
    axi_write("t3", 32'h8000_0030, 32'h0000_00FF, 4'h1, 0, 3);
    axi_write("t3b", 32'h8000_0034, 32'h0BAD_F00D, 4'hF, 2, 0);
    axi_write("t3z", 32'h8000_0034, 32'hFFFF_FFFF, 4'h0, 0, 0);
    axi_read("t3r", 32'h8000_0034, 0, got);
    check("t3/zero_strb", got, 32'h0BAD_F00D);

    // Backpressured read
    axi_read("t4", 32'h8000_0010, 5, got);

    // Out-of-range accesses
    axi_write("t5a", 32'h8000_0000, 32'h5A5A_1234, 4'hF, 0, 0);
    axi_read("t5r", 32'h7FFF_FFFC, 0, got);
    check("t5/oor_rdata", got, 32'h0);
    axi_write("t5w", 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_read("t5c", 32'h8000_0000, 0, got);
    check("t5/unchanged", got, 32'h5A5A_1234);

    // Same-cycle write commit and read sample on one word
    axi_write("t6a", 32'h8000_0040, 32'h0102_0304, 4'hF, 0, 0);
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h8000_0040;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    awvalid = 1'b1; awaddr = 32'h8000_0040;
    wvalid = 1'b1; wdata = 32'hF0E0_D0C0; wstrb = 4'b1010;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dummy = model_write(32'h8000_0040, 32'hF0E0_D0C0, 4'b1010);
    check("t6/rvalid", 32'(rvalid), 32'd1);
    check("t6/bvalid", 32'(bvalid), 32'd1);
    check("t6/bypass", rdata, 32'hF002_D004);
    check("t6/model", rdata, model_read(32'h8000_0040));
    rready = 1'b1; bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;

    // Reset during R_WAIT
    arvalid = 1'b1; araddr = 32'h8000_0010;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t7/rvalid", 32'(rvalid), 32'd0);
    check("t7/arready", 32'(arready), 32'd1);
    rst_n = 1'b1;
    axi_read("t7r", 32'h8000_0010, 0, got);
    check("t7/data_kept", got, 32'hDEAD_BEEF);

    // Reset during W_WAIT: pending write must not commit
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h8000_0010;
    wvalid = 1'b1; wdata = 32'h0; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t8/bvalid", 32'(bvalid), 32'd0);
    check("t8/ready", 32'({awready, wready}), 32'd3);
    rst_n = 1'b1;
    axi_read("t8r", 32'h8000_0010, 0, got);
    check("t8/no_commit", got, 32'hDEAD_BEEF);

    // Random mix over a small pool of words
    for (int i = 0; i < 8; i++) begin
      pool[i] = BASE + 32'($urandom_range(0, 4095)) * 32'd4;
      axi_write("rinit", pool[i], $urandom, 4'hF, 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        axi_write("rw", pool[$urandom_range(0, 7)], $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else begin
        addr_r = ($urandom_range(0, 7) == 0) ? (BASE + SPAN + 32'($urandom_range(0, 255)) * 32'd4)
                                             : pool[$urandom_range(0, 7)];
        axi_read("rr", addr_r, int'($urandom_range(0, 3)), got);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
